// File: rtl/channel_serializer_pkg.sv
// Shared definitions for the channel serializer slice.
//   DATA_W_DEF : default sample width in bits
//   state_t    : output FSM state encoding (IDLE / SEND)
//   idx_w()    : width of an index over n items (never less than 1)
package cnn_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/channel_serializer_if.sv
// Bundle of the serializer's data-path signals.
//   din/vin          : packed channel samples and per-channel valid pulses
//   dout/vout        : serial signed sample and its valid
//   out_ready        : downstream accept
//   dch/dlast        : channel index of dout, high on the last channel
//   ovf/clr_ovf      : sticky overflow flag and its clear
// master = traffic source / sink side, slave = the serializer.
interface channel_serializer_if import cnn_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CH     = 3
);
  logic [CH*DATA_W-1:0]     din;
  logic [CH-1:0]            vin;
  logic signed [DATA_W-1:0] dout;
  logic                     vout;
  logic                     out_ready;
  logic [idx_w(CH)-1:0]     dch;
  logic                     dlast;
  logic                     ovf;
  logic                     clr_ovf;

  modport master (
    output din, vin, out_ready, clr_ovf,
    input  dout, vout, dch, dlast, ovf
  );

  modport slave (
    input  din, vin, out_ready, clr_ovf,
    output dout, vout, dch, dlast, ovf
  );
endinterface

// File: rtl/channel_serializer_frame_fifo.sv
// frame_fifo: small frame buffer holding complete multi-channel frames.
//   clk, rst   : clock, synchronous active-high reset
//   i_push     : write i_data (ignored when full)
//   i_pop      : drop the head frame (ignored when empty)
//   o_head     : frame at the read pointer
//   o_second   : frame after the head (valid only when o_count > 1)
//   o_full, o_empty, o_count : occupancy, all from registered state
module frame_fifo import cnn_pkg::*; #(
  parameter int W     = 24,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic [W-1:0]           i_data,
  input  logic                   i_pop,
  output logic [W-1:0]           o_head,
  output logic [W-1:0]           o_second,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int PTR_W = idx_w(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Depth is a power of two, so pointers wrap by natural overflow.
  assign o_head   = r_mem[r_rd_ptr];
  assign o_second = r_mem[r_rd_ptr + PTR_W'(1)];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/channel_serializer.sv
// channel_serializer: collects one sample per channel (arriving in any
// cycles) into a frame, buffers whole frames, and emits them as a serial
// stream channel 0..CH-1 with a valid/ready handshake.
//   clk, rst : clock, synchronous active-high reset
//   bus      : channel_serializer_if.slave (din/vin in, dout/vout/dch/dlast
//              out, out_ready in, ovf out, clr_ovf in)
module channel_serializer import cnn_pkg::*; #(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int CH          = 3,
  parameter int FRAME_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  channel_serializer_if.slave  bus
);
  localparam int CH_W  = idx_w(CH);
  localparam int FW    = CH * DATA_W;
  localparam int CNT_W = $clog2(FRAME_DEPTH) + 1;

  // Staging
  logic [DATA_W-1:0] r_stage [CH];
  logic [CH-1:0]     r_flag;
  logic              r_ovf;
  logic [CH-1:0]     w_dup;
  logic [FW-1:0]     w_frame;
  logic              w_complete;
  logic              w_push;

  // Frame buffer
  logic [FW-1:0]     w_head;
  logic [FW-1:0]     w_second;
  logic              w_full;
  logic              w_empty;
  logic [CNT_W-1:0]  w_count;
  logic              w_pop;

  // Output FSM
  state_t                   r_state, w_state_next;
  logic signed [DATA_W-1:0] r_dout, w_dout_next;
  logic                     r_vout, w_vout_next;
  logic [CH_W-1:0]          r_dch, w_dch_next;
  logic                     r_dlast, w_dlast_next;
  logic [CH_W-1:0]          w_next_ch;
  logic [FW-1:0]            w_src;
  logic [CH_W-1:0]          w_src_ch;

  assign w_dup      = bus.vin & r_flag;
  assign w_complete = &(r_flag | bus.vin);
  // Fullness is the registered state, so a same-cycle pop cannot admit a push.
  assign w_push     = w_complete && !w_full;

  // A frame may complete with some channels arriving this very cycle: those
  // lanes bypass the staging register. A duplicate pulse on a flagged lane
  // loses to the stored sample.
  for (genvar gi = 0; gi < CH; gi++) begin : g_frame
    assign w_frame[gi*DATA_W +: DATA_W] =
      r_flag[gi] ? r_stage[gi] : bus.din[gi*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_flag <= '0;
      for (int i = 0; i < CH; i++) r_stage[i] <= '0;
    end else if (w_push) begin
      r_flag <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (bus.vin[i] && !r_flag[i]) begin
          r_flag[i]  <= 1'b1;
          r_stage[i] <= bus.din[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Setting wins over clearing when both happen in one cycle.
  always_ff @(posedge clk) begin
    if (rst)            r_ovf <= 1'b0;
    else if (|w_dup)    r_ovf <= 1'b1;
    else if (bus.clr_ovf) r_ovf <= 1'b0;
  end

  frame_fifo #(
    .W     (FW),
    .DEPTH (FRAME_DEPTH)
  ) u_frame_fifo (
    .clk      (clk),
    .rst      (rst),
    .i_push   (w_push),
    .i_data   (w_frame),
    .i_pop    (w_pop),
    .o_head   (w_head),
    .o_second (w_second),
    .o_full   (w_full),
    .o_empty  (w_empty),
    .o_count  (w_count)
  );

  assign w_next_ch = r_dch + CH_W'(1);

  // After the last channel of the head frame the next load comes from the
  // following frame (no bubble); otherwise it is the next lane of the head.
  always_comb begin
    w_src    = w_head;
    w_src_ch = '0;
    if (r_state == ST_SEND) begin
      if (r_dlast) w_src = w_second;
      else         w_src_ch = w_next_ch;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_dout  <= '0;
      r_vout  <= 1'b0;
      r_dch   <= '0;
      r_dlast <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_dout  <= w_dout_next;
      r_vout  <= w_vout_next;
      r_dch   <= w_dch_next;
      r_dlast <= w_dlast_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_dout_next  = r_dout;
    w_vout_next  = r_vout;
    w_dch_next   = r_dch;
    w_dlast_next = r_dlast;
    w_pop        = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_dout_next  = w_src[int'(w_src_ch)*DATA_W +: DATA_W];
          w_vout_next  = 1'b1;
          w_dch_next   = '0;
          w_dlast_next = 1'b0;
          w_state_next = ST_SEND;
        end
      end
      ST_SEND: begin
        if (r_vout && bus.out_ready) begin
          if (r_dlast) begin
            w_pop = 1'b1;
            if (w_count > CNT_W'(1)) begin
              w_dout_next  = w_src[int'(w_src_ch)*DATA_W +: DATA_W];
              w_dch_next   = '0;
              w_dlast_next = 1'b0;
            end else begin
              w_vout_next  = 1'b0;
              w_dlast_next = 1'b0;
              w_state_next = ST_IDLE;
            end
          end else begin
            w_dout_next  = w_src[int'(w_src_ch)*DATA_W +: DATA_W];
            w_dch_next   = w_next_ch;
            w_dlast_next = (w_next_ch == CH_W'(CH - 1));
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign bus.dout  = r_dout;
  assign bus.vout  = r_vout;
  assign bus.dch   = r_dch;
  assign bus.dlast = r_dlast;
  assign bus.ovf   = r_ovf;
endmodule

// File: doc/channel_serializer.md
CHANNEL_SERIALIZER -- requirements
Module: channel_serializer

Interface
REQ-001 Parameter DATA_W, default 8, sample width in bits (signed two's complement).
REQ-002 Parameter CH, default 3, number of parallel input channels (2..16).
REQ-003 Parameter FRAME_DEPTH, default 2, frame buffer slots (power of two, >=2).
REQ-004 clk  input  1  sole clock, all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 din  input  CH*DATA_W  packed channel samples; channel i at bits [i*DATA_W +: DATA_W].
REQ-007 vin  input  CH  per-channel valid pulses; channels may arrive in different cycles.
REQ-008 dout  output  DATA_W  serial sample, signed, registered.
REQ-009 vout  output  1  dout valid.
REQ-010 out_ready  input  1  downstream accepts dout when vout&&out_ready.
REQ-011 dch  output  $clog2(CH)  channel index of current dout.
REQ-012 dlast  output  1  high with the last channel (CH-1) of a frame.
REQ-013 ovf  output  1  sticky overflow flag.
REQ-014 clr_ovf  input  1  clears ovf.

Function
REQ-015 Staging: per-channel register plus full flag; vin[i] with flag clear captures din slice i and sets flag.
REQ-016 vin[i] with flag[i] already set SHALL drop the new sample, keep the stored one, and set ovf.
REQ-017 Frame complete when every channel is either flagged or captured this cycle; on that edge, if frame FIFO not full, push all CH samples and clear all flags.
REQ-018 If FIFO full at frame completion, flags stay set; push retried every cycle until a slot frees; vin during the wait follows REQ-016.
REQ-019 Full is evaluated at cycle start; a pop in the same cycle does not admit a push (no pass-through).
REQ-020 Output FSM states IDLE, SEND. IDLE: FIFO non-empty -> load channel 0 of head frame, vout=1, dch=0, go SEND.
REQ-021 SEND, vout&&out_ready, dch<CH-1: present next channel next cycle.
REQ-022 SEND, vout&&out_ready, dch==CH-1: pop head; if another frame is stored, load its channel 0 next cycle (no bubble), else vout=0, go IDLE.
REQ-023 While vout&&!out_ready, dout, dch, dlast SHALL hold stable.
REQ-024 Latency: all vin high in cycle 0, FIFO empty, IDLE -> vout=1 with channel 0 in cycle 2.
REQ-025 Peak throughput one sample per cycle; frames emitted in arrival order, channels in ascending index.
REQ-026 ovf set has priority over clr_ovf in the same cycle.
REQ-027 No arithmetic on data; samples pass bit-exact.

Reset
REQ-028 rst high at any edge: vout=0, dout=0, dch=0, dlast=0, ovf=0, all flags clear, FIFO empty, FSM IDLE.
REQ-029 Reset mid-frame discards staged and buffered frames; no partial frame emitted after reset.
REQ-030 vin during rst is ignored.

Structure
REQ-031 DATA_W default and FSM state encoding live in shared package cnn_pkg.
REQ-032 Frame buffer is sub-module frame_fifo (width CH*DATA_W, depth FRAME_DEPTH, registered pointers, full/empty/count).
REQ-033 Target size 150-300 lines RTL total.

Verification
REQ-034 CH=3, vin=3'b111, din={-3,2,5}, out_ready=1 -> cycles 2,3,4: dout 5,2,-3, dch 0,1,2, dlast only in cycle 4.
REQ-035 vin[0] cycle 0, vin[2] cycle 3, vin[1] cycle 5 -> single frame, vout starts cycle 7, ovf=0.
REQ-036 vin[1] pulsed twice before frame completes (values 10 then 20) -> 10 emitted, ovf=1; clr_ovf -> ovf=0 next cycle.
REQ-037 out_ready=0, three back-to-back full frames, FRAME_DEPTH=2 -> two buffered, third held in staging, fourth vin sets ovf; release out_ready -> 9 samples contiguous, correct order.
REQ-038 out_ready toggled every cycle during a frame -> dout stable while stalled, no sample lost or repeated.
REQ-039 rst asserted after channel 1 of a frame emitted -> vout=0 next cycle, no further output until a new full frame arrives.
